// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the iteration-counter width helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mduOp_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mduState_t;

    // Counter runs WordLen-1 down to 0.
    function automatic int unsigned cntWidth(input int unsigned wordLen);
        return $clog2(wordLen);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring-subtract divide.
// accHi is one bit wider than a word to hold the add carry / trial sign.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WordLen = 32
) (
    input  logic               isDiv,
    input  logic [WordLen:0]   accHi,
    input  logic [WordLen-1:0] accLo,
    input  logic [WordLen-1:0] operand,
    output logic [WordLen:0]   nextHi,
    output logic [WordLen-1:0] nextLo
);

    logic [WordLen:0] addSum;
    logic [WordLen:0] shifted;
    logic [WordLen:0] trial;

    // Compute both candidate updates and select by mode.
    always_comb begin
        addSum  = accHi + (accLo[0] ? {1'b0, operand} : '0);
        shifted = {accHi[WordLen-1:0], accLo[WordLen-1]};
        trial   = shifted - {1'b0, operand};
        nextHi  = {1'b0, addSum[WordLen:1]};
        nextLo  = {addSum[0], accLo[WordLen-1:1]};
        if (isDiv) begin
            if (!trial[WordLen]) begin
                nextHi = trial;
                nextLo = {accLo[WordLen-2:0], 1'b1};
            end else begin
                nextHi = shifted;
                nextLo = {accLo[WordLen-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/iterative_mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing hi/lo, one bit per cycle.
// Optional: define MDU_FAST_ZERO_EN to finish zero-operand multiplies and
// divide-by-zero directly from IDLE (results are identical either way).
module iterative_mul_div
    import mdu_pkg::*;
#(
    parameter int unsigned WordLen = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WordLen-1:0] srcA,
    input  logic [WordLen-1:0] srcB,
    output logic               busy,
    output logic               done,
    output logic [WordLen-1:0] hi,
    output logic [WordLen-1:0] lo,
    output logic               divByZero
);

    localparam int unsigned CntW = cntWidth(WordLen);

    mduState_t          state, stateNext;
    mduOp_t             opReg;
    logic [WordLen-1:0] aReg, bReg, operand;
    logic [WordLen:0]   accHi, stepHi;
    logic [WordLen-1:0] accLo, stepLo;
    logic [CntW-1:0]    count;
    logic               negLo, negHi, divZero;

    logic               isDiv, isSigned, signA, signB, zeroB, fastZero;
    logic [WordLen-1:0] magA, magB;
    logic [WordLen-1:0] resHi, resLo;
    logic               resDz;
    logic [2*WordLen-1:0] prod;

    assign isDiv    = (opReg == OP_DIV) || (opReg == OP_DIVU);
    assign isSigned = (opReg == OP_MULT) || (opReg == OP_DIV);
    assign signA    = isSigned && aReg[WordLen-1];
    assign signB    = isSigned && bReg[WordLen-1];
    assign magA     = signA ? -aReg : aReg;
    assign magB     = signB ? -bReg : bReg;
    assign zeroB    = (bReg == '0);

`ifdef MDU_FAST_ZERO_EN
    assign fastZero = start && (op[1] ? (srcB == '0) : ((srcA == '0) || (srcB == '0)));
`else
    assign fastZero = 1'b0;
`endif

    mdu_step #(.WordLen(WordLen)) u_step (
        .isDiv   (isDiv),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = fastZero ? DONE : LOAD;
            LOAD: stateNext = RUN;
            RUN:  if (count == '0) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Final result: sign fix-up of the accumulators, or the shortcut values from IDLE.
    always_comb begin
        resHi = '0;
        resLo = '0;
        resDz = 1'b0;
        prod  = {accHi[WordLen-1:0], accLo};
        if (state == IDLE) begin
            if (op[1]) begin
                resHi = srcA;
                resLo = '1;
                resDz = 1'b1;
            end
        end else if (isDiv) begin
            resLo = negLo ? -accLo : accLo;
            resHi = negHi ? -accHi[WordLen-1:0] : accHi[WordLen-1:0];
            resDz = divZero;
        end else begin
            {resHi, resLo} = negLo ? -prod : prod;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opReg     <= OP_MULT;
            aReg      <= '0;
            bReg      <= '0;
            operand   <= '0;
            accHi     <= '0;
            accLo     <= '0;
            count     <= '0;
            negLo     <= 1'b0;
            negHi     <= 1'b0;
            divZero   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg <= mduOp_t'(op);
                        aReg  <= srcA;
                        bReg  <= srcB;
                    end
                end
                LOAD: begin
                    accHi <= '0;
                    count <= CntW'(WordLen - 1);
                    if (isDiv) begin
                        // Divide by zero keeps the raw dividend so hi returns srcA unchanged.
                        accLo   <= zeroB ? aReg : magA;
                        operand <= magB;
                        divZero <= zeroB;
                        negLo   <= !zeroB && (signA ^ signB);
                        negHi   <= !zeroB && signA;
                    end else begin
                        accLo   <= magB;
                        operand <= magA;
                        divZero <= 1'b0;
                        negLo   <= signA ^ signB;
                        negHi   <= 1'b0;
                    end
                end
                RUN: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count - CntW'(1);
                end
                default: ;
            endcase

            busy      <= (stateNext != IDLE);
            done      <= (stateNext == DONE);
            divByZero <= (stateNext == DONE) && resDz;
            if (stateNext == DONE) begin
                hi <= resHi;
                lo <= resLo;
            end
        end
    end

endmodule

// File: tb/tb_iterative_mul_div.sv
// Directed self-checking bench for iterative_mul_div (WordLen = 32).
module tb_iterative_mul_div;

    localparam int unsigned W = 32;
    localparam int FullLat = W + 3;
`ifdef MDU_FAST_ZERO_EN
    localparam int FastLat = 1;
`else
    localparam int FastLat = W + 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  srcA, srcB;
    logic          busy, done, divByZero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    iterative_mul_div #(.WordLen(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op and follow it until busy drops (bounded), checking results and timing.
    task automatic doOp(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] expHi,
                        input logic [W-1:0] expLo, input logic expDz, input int expLat,
                        input bit poke);
        int busyCycles = 0;
        int doneAt = 0;
        int doneCount = 0;
        logic gotDz = 1'b0;
        logic [W-1:0] gotHi = '0, gotLo = '0;
        logic [W-1:0] prevHi, prevLo;
        bit holdOk = 1'b1;
        @(negedge clk);
        prevHi = hi;
        prevLo = lo;
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (!busy) break;
            busyCycles++;
            if (done) begin
                doneCount++;
                doneAt = i;
                gotHi = hi;
                gotLo = lo;
                gotDz = divByZero;
            end else if (hi !== prevHi || lo !== prevLo) begin
                holdOk = 1'b0;
            end
            start = 1'b0;
            if (poke && (i == 5 || i == 20)) begin
                op = 2'b11; srcA = 32'd99; srcB = 32'd7; start = 1'b1;
            end
            if (poke && done) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".hi"}, 64'(gotHi), 64'(expHi));
        chk({tag, ".lo"}, 64'(gotLo), 64'(expLo));
        chk({tag, ".divByZero"}, 64'(gotDz), 64'(expDz));
        chk({tag, ".busyCycles"}, 64'(busyCycles), 64'(expLat));
        chk({tag, ".doneAt"}, 64'(doneAt), 64'(expLat));
        chk({tag, ".doneCount"}, 64'(doneCount), 64'd1);
        chk({tag, ".holdWhileBusy"}, 64'(holdOk), 64'd1);
        if (poke) begin
            @(negedge clk);
            chk({tag, ".startInDoneIgnored"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int doneSeen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.divByZero", 64'(divByZero), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        doOp("multuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, FullLat, 1'b0);
        doOp("multNeg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, FullLat, 1'b0);
        doOp("divNegA", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, FullLat, 1'b0);
        doOp("divNegB", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, FullLat, 1'b0);
        doOp("divuByZero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, FastLat, 1'b0);
        doOp("divByZeroNeg", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, FastLat, 1'b0);
        doOp("divMinByNeg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, FullLat, 1'b0);
        doOp("multZero", 2'b00, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b0, FastLat, 1'b0);
        doOp("multuPoked", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, FullLat, 1'b1);

        // Reset during RUN iteration 10 (LOAD is busy cycle 1, iteration k is cycle k+2).
        doOp("divuPreReset", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, FullLat, 1'b0);
        @(negedge clk);
        op = 2'b01; srcA = 32'd12345; srcB = 32'd678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midReset.busy", 64'(busy), 64'd0);
        chk("midReset.done", 64'(done), 64'd0);
        chk("midReset.hi", 64'(hi), 64'd0);
        chk("midReset.lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 50; i++) begin
            if (done || busy) doneSeen++;
            @(negedge clk);
        end
        chk("midReset.noDoneAfter", 64'(doneSeen), 64'd0);
        doOp("divuAfterReset", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, FullLat, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
